// File: rtl/pe_pkg.sv
// Shared definitions for the pe_dbuf processing element: op_in bit positions,
// dataflow mode encoding and the product-sum width helper.
package pe_pkg;

   localparam int OP_WIDTH = 4;
   localparam int OP_MODE  = 3;
   localparam int OP_DRAIN = 2;
   localparam int OP_LOAD  = 1;
   localparam int OP_SWAP  = 0;

   typedef enum logic {
      MODE_WS = 1'b0,
      MODE_OS = 1'b1
   } pe_mode_e;

   // Wide enough for LANES full-scale signed products added together.
   function automatic int psum_width(input int act_w, input int wgt_w, input int lanes);
      return act_w + wgt_w + $clog2(lanes);
   endfunction

endpackage

// File: rtl/pe_wgt_bank.sv
// Double-buffered weight storage: one active bank feeding the multipliers and
// one shadow bank that can be refilled while the active one is in use.
module pe_wgt_bank #(
   parameter int BANK_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  swap,
   input  logic [BANK_WIDTH-1:0] wgt_data_in,
   output logic [BANK_WIDTH-1:0] active_wgt
);

   logic [BANK_WIDTH-1:0] bank_reg [2];
   logic                  ptr_reg;

   // The shadow bank is chosen by the pointer value before any same-cycle
   // swap, so load+swap publishes the freshly written data next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         bank_reg[0] <= '0;
         bank_reg[1] <= '0;
      end else if (load) begin
         bank_reg[~ptr_reg] <= wgt_data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg <= 1'b0;
      end else if (swap) begin
         ptr_reg <= ~ptr_reg;
      end
   end

   assign active_wgt = bank_reg[ptr_reg];

endmodule

// File: rtl/pe_dbuf.sv
// Two-stage multi-lane MAC processing element with double-buffered weights,
// supporting weight-stationary and output-stationary dataflow.
// Define PE_SAT_EN for saturating accumulation with a sticky sat_flag.
module pe_dbuf
   import pe_pkg::*;
#(
   parameter int ACT_WIDTH    = 8,
   parameter int WGT_WIDTH    = 8,
   parameter int LANES        = 4,
   parameter int PE_OUT_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [OP_WIDTH-1:0]           op_in,
   input  logic                          act_valid_in,
   input  logic [LANES*ACT_WIDTH-1:0]    act_data_in,
   input  logic [LANES*WGT_WIDTH-1:0]    wgt_data_in,
   input  logic [PE_OUT_WIDTH-1:0]       result_in,
   output logic [LANES*ACT_WIDTH-1:0]    act_data_out,
   output logic                          act_valid_out,
   output logic [PE_OUT_WIDTH-1:0]       result_out,
   output logic                          sat_flag
);

   localparam int PSUM_W = psum_width(ACT_WIDTH, WGT_WIDTH, LANES);
   localparam int PROD_W = ACT_WIDTH + WGT_WIDTH;
   localparam int VEC_W  = LANES * WGT_WIDTH;

   pe_mode_e                        op_mode;
   logic [VEC_W-1:0]                active_wgt;
   logic [VEC_W-1:0]                mul_wgt;
   logic signed [PROD_W-1:0]        prod [LANES];
   logic signed [PSUM_W-1:0]        psum_next;

   logic signed [PSUM_W-1:0]        psum_reg;
   logic                            s1_valid_reg;
   logic                            s1_drain_reg;
   logic                            s1_live_reg;
   pe_mode_e                        s1_mode_reg;
   logic [LANES*ACT_WIDTH-1:0]      act_data_reg;
   logic                            act_valid_reg;

   logic signed [PE_OUT_WIDTH-1:0]  acc_reg;
   logic signed [PE_OUT_WIDTH-1:0]  acc_next;
   logic signed [PE_OUT_WIDTH-1:0]  add_base;
   logic signed [PE_OUT_WIDTH-1:0]  sum_fit;

   assign op_mode = pe_mode_e'(op_in[OP_MODE]);

   pe_wgt_bank #(
      .BANK_WIDTH (VEC_W)
   ) u_wgt_bank (
      .clk         (clk),
      .reset       (reset),
      .load        (op_in[OP_LOAD]),
      .swap        (op_in[OP_SWAP]),
      .wgt_data_in (wgt_data_in),
      .active_wgt  (active_wgt)
   );

   // OS streams the weight operand alongside the activation; WS uses storage.
   assign mul_wgt = (op_mode == MODE_OS) ? wgt_data_in : active_wgt;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : gen_lane
         assign prod[gi] = $signed(act_data_in[gi*ACT_WIDTH +: ACT_WIDTH])
                         * $signed(mul_wgt[gi*WGT_WIDTH +: WGT_WIDTH]);
      end
   endgenerate

   always_comb begin
      psum_next = '0;
      for (int i = 0; i < LANES; i++) begin
         psum_next = psum_next + PSUM_W'(prod[i]);
      end
   end

   // s1_live_reg marks that stage 1 holds a post-reset vector, so the
   // accumulator stays at zero for the first cycle after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         psum_reg      <= '0;
         s1_valid_reg  <= 1'b0;
         s1_drain_reg  <= 1'b0;
         s1_live_reg   <= 1'b0;
         s1_mode_reg   <= MODE_WS;
         act_data_reg  <= '0;
         act_valid_reg <= 1'b0;
      end else begin
         psum_reg      <= psum_next;
         s1_valid_reg  <= act_valid_in;
         s1_drain_reg  <= op_in[OP_DRAIN];
         s1_live_reg   <= 1'b1;
         s1_mode_reg   <= op_mode;
         act_data_reg  <= act_data_in;
         act_valid_reg <= act_valid_in;
      end
   end

   assign act_data_out  = act_data_reg;
   assign act_valid_out = act_valid_reg;

   assign add_base = (s1_mode_reg == MODE_OS) ? acc_reg : $signed(result_in);

`ifdef PE_SAT_EN
   localparam logic signed [PE_OUT_WIDTH-1:0] ACC_MAX = {1'b0, {(PE_OUT_WIDTH-1){1'b1}}};
   localparam logic signed [PE_OUT_WIDTH-1:0] ACC_MIN = {1'b1, {(PE_OUT_WIDTH-1){1'b0}}};

   logic signed [PE_OUT_WIDTH:0] sum_wide;
   logic                         sum_ovf;
   logic                         sat_set;
   logic                         sat_reg;

   // One guard bit: overflow shows up as disagreement of the top two bits.
   assign sum_wide = {add_base[PE_OUT_WIDTH-1], add_base} + (PE_OUT_WIDTH+1)'(psum_reg);
   assign sum_ovf  = sum_wide[PE_OUT_WIDTH] ^ sum_wide[PE_OUT_WIDTH-1];
   assign sum_fit  = !sum_ovf ? sum_wide[PE_OUT_WIDTH-1:0]
                   : (sum_wide[PE_OUT_WIDTH] ? ACC_MIN : ACC_MAX);
   assign sat_set  = s1_live_reg && !s1_drain_reg && s1_valid_reg && sum_ovf;

   always_ff @(posedge clk) begin
      if (reset) begin
         sat_reg <= 1'b0;
      end else if (sat_set) begin
         sat_reg <= 1'b1;
      end
   end

   assign sat_flag = sat_reg;
`else
   assign sum_fit  = add_base + PE_OUT_WIDTH'(psum_reg);
   assign sat_flag = 1'b0;
`endif

   // Drain overrides accumulation; an empty WS slot still passes result_in.
   always_comb begin
      acc_next = acc_reg;
      if (s1_live_reg) begin
         if (s1_drain_reg) begin
            acc_next = $signed(result_in);
         end else if (s1_valid_reg) begin
            acc_next = sum_fit;
         end else if (s1_mode_reg == MODE_WS) begin
            acc_next = $signed(result_in);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_reg <= '0;
      end else begin
         acc_reg <= acc_next;
      end
   end

   assign result_out = acc_reg;

endmodule

// File: tb/tb_pe_dbuf.sv
// Self-checking bench for pe_dbuf: directed scenarios plus randomized traffic
// compared against an integer-arithmetic reference model.
module tb_pe_dbuf;

   localparam int A  = 8;
   localparam int W  = 8;
   localparam int L  = 4;
   localparam int PW = 32;

   localparam logic [3:0] OP_NONE  = 4'b0000;
   localparam logic [3:0] OP_SWAP  = 4'b0001;
   localparam logic [3:0] OP_LOAD  = 4'b0010;
   localparam logic [3:0] OP_DRAIN = 4'b0100;
   localparam logic [3:0] OP_OS    = 4'b1000;

   logic            clk = 1'b0;
   logic            reset;
   logic [3:0]      op_in;
   logic            act_valid_in;
   logic [L*A-1:0]  act_data_in;
   logic [L*W-1:0]  wgt_data_in;
   logic [PW-1:0]   result_in;
   logic [L*A-1:0]  act_data_out;
   logic            act_valid_out;
   logic [PW-1:0]   result_out;
   logic            sat_flag;

   always #5 clk = ~clk;

   pe_dbuf #(
      .ACT_WIDTH    (A),
      .WGT_WIDTH    (W),
      .LANES        (L),
      .PE_OUT_WIDTH (PW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .op_in         (op_in),
      .act_valid_in  (act_valid_in),
      .act_data_in   (act_data_in),
      .wgt_data_in   (wgt_data_in),
      .result_in     (result_in),
      .act_data_out  (act_data_out),
      .act_valid_out (act_valid_out),
      .result_out    (result_out),
      .sat_flag      (sat_flag)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model state: plain integers, banks as whole vectors.
   longint         m_acc;
   bit             m_sat;
   logic [L*W-1:0] m_bank [2];
   bit             m_ptr;
   bit             s1_live, s1_v, s1_mode, s1_drain;
   longint         s1_psum;
   logic [L*A-1:0] m_aout;
   bit             m_vout;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      return {d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   function automatic longint dot(input logic [L*A-1:0] av, input logic [L*W-1:0] wv);
      longint s;
      logic signed [A-1:0] x;
      logic signed [W-1:0] y;
      s = 0;
      for (int i = 0; i < L; i++) begin
         x = av[i*A +: A];
         y = wv[i*W +: W];
         s += longint'(x) * longint'(y);
      end
      return s;
   endfunction

   function automatic longint fit(input longint x, output bit ovf);
      longint maxv, minv;
      logic [PW-1:0] t;
      maxv = (longint'(1) <<< (PW-1)) - 1;
      minv = -(longint'(1) <<< (PW-1));
      ovf  = (x > maxv) || (x < minv);
`ifdef PE_SAT_EN
      if (x > maxv) return maxv;
      if (x < minv) return minv;
      return x;
`else
      t = x[PW-1:0];
      return longint'($signed(t));
`endif
   endfunction

   task automatic model_step(input bit rst, input logic [3:0] op, input bit av,
                             input logic [L*A-1:0] ad, input logic [L*W-1:0] wd,
                             input logic [PW-1:0] ri);
      bit     ovf;
      longint r_in;
      if (rst) begin
         m_acc = 0; m_sat = 0; m_bank[0] = '0; m_bank[1] = '0; m_ptr = 0;
         s1_live = 0; s1_v = 0; s1_mode = 0; s1_drain = 0; s1_psum = 0;
         m_aout = '0; m_vout = 0;
      end else begin
         ovf  = 0;
         r_in = longint'($signed(ri));
         if (s1_live) begin
            if (s1_drain) m_acc = r_in;
            else if (s1_v) m_acc = fit((s1_mode ? m_acc : r_in) + s1_psum, ovf);
            else if (!s1_mode) m_acc = r_in;
         end
`ifdef PE_SAT_EN
         if (ovf) m_sat = 1;
`endif
         s1_psum  = dot(ad, op[3] ? wd : m_bank[m_ptr]);
         s1_v     = av;
         s1_mode  = op[3];
         s1_drain = op[2];
         s1_live  = 1;
         if (op[1]) m_bank[!m_ptr] = wd;
         if (op[0]) m_ptr = !m_ptr;
         m_aout = ad;
         m_vout = av;
      end
   endtask

   task automatic cycle(input bit rst, input logic [3:0] op, input bit av,
                        input logic [L*A-1:0] ad, input logic [L*W-1:0] wd,
                        input logic [PW-1:0] ri);
      logic [PW-1:0] e_res;
      reset = rst; op_in = op; act_valid_in = av;
      act_data_in = ad; wgt_data_in = wd; result_in = ri;
      @(posedge clk);
      model_step(rst, op, av, ad, wd, ri);
      #1;
      cyc++;
      e_res = m_acc[PW-1:0];
      check("result_out", 64'(result_out), 64'(e_res));
      check("act_valid_out", 64'(act_valid_out), 64'(m_vout));
      check("act_data_out", 64'(act_data_out), 64'(m_aout));
      check("sat_flag", 64'(sat_flag), 64'(m_sat));
      $display("txn %0d rst=%0b op=%h av=%0b act=%h wgt=%h rin=%h res=%h sat=%0b",
               cyc, rst, op, av, ad, wd, ri, result_out, sat_flag);
   endtask

   initial begin
      logic [31:0] ones, twos, rnd_ad, rnd_wd, rnd_ri;
      logic [3:0]  rnd_op;
      ones = pk(1, 1, 1, 1);
      twos = pk(2, 2, 2, 2);

      // Reset, then the first post-reset cycle must still show zero.
      cycle(1, OP_NONE, 0, '0, '0, '0);
      cycle(1, OP_NONE, 0, '0, '0, '0);
      check("reset_result", 64'(result_out), 64'd0);
      cycle(0, OP_NONE, 0, '0, '0, 32'd77);
      check("post_reset_result", 64'(result_out), 64'd0);

      // WS: load [1,2,3,4], swap, dot with ones plus 100.
      cycle(0, OP_LOAD, 0, '0, pk(1, 2, 3, 4), '0);
      cycle(0, OP_SWAP, 0, '0, '0, '0);
      cycle(0, OP_NONE, 1, ones, '0, '0);
      cycle(0, OP_NONE, 0, '0, '0, 32'd100);
      check("ws_basic", 64'(result_out), 64'd110);

      // Load+swap in one cycle makes the new bank active immediately after.
      cycle(0, OP_LOAD, 0, '0, twos, '0);
      cycle(0, OP_SWAP, 0, '0, '0, '0);
      cycle(0, OP_LOAD | OP_SWAP, 0, '0, pk(-1, -1, -1, -1), '0);
      cycle(0, OP_NONE, 1, pk(3, 0, 0, 0), '0, '0);
      cycle(0, OP_NONE, 0, '0, '0, '0);
      check("load_swap", 64'(result_out), 64'(32'hFFFF_FFFD));

      // OS accumulate, hold on invalid, drain.
      cycle(0, OP_OS | OP_DRAIN, 0, '0, '0, '0);
      cycle(0, OP_OS, 1, twos, ones, '0);
      check("os_clear", 64'(result_out), 64'd0);
      cycle(0, OP_OS, 1, twos, ones, '0);
      check("os_acc1", 64'(result_out), 64'd8);
      cycle(0, OP_OS, 1, twos, ones, '0);
      check("os_acc2", 64'(result_out), 64'd16);
      cycle(0, OP_OS, 0, '0, '0, '0);
      check("os_acc3", 64'(result_out), 64'd24);
      cycle(0, OP_OS | OP_DRAIN, 0, '0, '0, '0);
      check("os_hold", 64'(result_out), 64'd24);
      cycle(0, OP_OS, 0, '0, '0, 32'd7);
      check("os_drain", 64'(result_out), 64'd7);

      // Overflow: 0x7FFFFFF0 + 32.
      cycle(0, OP_OS | OP_DRAIN, 0, '0, '0, '0);
      cycle(0, OP_OS, 1, pk(8, 0, 0, 0), pk(4, 0, 0, 0), 32'h7FFF_FFF0);
      check("ovf_preload", 64'(result_out), 64'(32'h7FFF_FFF0));
      cycle(0, OP_OS, 0, '0, '0, '0);
`ifdef PE_SAT_EN
      check("ovf_result", 64'(result_out), 64'(32'h7FFF_FFFF));
      check("ovf_flag", 64'(sat_flag), 64'd1);
`else
      check("ovf_result", 64'(result_out), 64'(32'h8000_0010));
      check("ovf_flag", 64'(sat_flag), 64'd0);
`endif

      // Reset in the middle of OS accumulation with a valid vector in flight.
      cycle(0, OP_OS | OP_DRAIN, 1, twos, ones, '0);
      cycle(0, OP_OS, 1, twos, ones, '0);
      cycle(1, OP_OS | OP_LOAD | OP_SWAP, 1, twos, ones, 32'd55);
      check("mid_reset_result", 64'(result_out), 64'd0);
      check("mid_reset_valid", 64'(act_valid_out), 64'd0);
      check("mid_reset_sat", 64'(sat_flag), 64'd0);
      cycle(0, OP_NONE, 1, ones, '0, 32'd555);
      check("mid_reset_hold", 64'(result_out), 64'd0);
      cycle(0, OP_SWAP, 1, ones, '0, '0);
      check("bank0_cleared", 64'(result_out), 64'd0);
      cycle(0, OP_NONE, 0, '0, '0, '0);
      check("bank1_cleared", 64'(result_out), 64'd0);

      // Randomized traffic with occasional resets and mode changes.
      for (int n = 0; n < 700; n++) begin
         rnd_op    = 4'($urandom);
         rnd_op[2] = ($urandom_range(0, 7) == 0);
         rnd_ad    = $urandom;
         rnd_wd    = $urandom;
         if ($urandom_range(0, 3) == 0) rnd_ri = $urandom;
         else rnd_ri = 32'($urandom_range(0, 2000)) - 32'd1000;
         cycle(($urandom_range(0, 49) == 0), rnd_op, 1'($urandom), rnd_ad, rnd_wd, rnd_ri);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pe_dbuf.md
PE_DBUF -- requirements
Module: pe_dbuf

Interface
REQ-001 Parameter ACT_WIDTH, default 8, signed activation width per lane SHALL be provided.
REQ-002 Parameter WGT_WIDTH, default 8, signed weight width per lane SHALL be provided.
REQ-003 Parameter LANES, default 4, number of parallel MAC lanes summed per cycle SHALL be provided.
REQ-004 Parameter PE_OUT_WIDTH, default 32, signed accumulator/result width SHALL be provided.
REQ-005 Port clk  input  1  single clock; all logic SHALL be rising-edge clk, no other clock.
REQ-006 Port reset  input  1  synchronous active-high reset.
REQ-007 Port op_in  input  4  [3]=mode (1 OS, 0 WS), [2]=os_drain, [1]=wgt_load, [0]=wgt_swap.
REQ-008 Port act_valid_in  input  1  act_data_in qualifier.
REQ-009 Port act_data_in  input  LANES*ACT_WIDTH  packed signed activations, lane 0 at LSBs.
REQ-010 Port wgt_data_in  input  LANES*WGT_WIDTH  packed signed weights (load data in WS, streamed operand in OS).
REQ-011 Port result_in  input  PE_OUT_WIDTH  upstream partial sum (WS) or drain data (OS).
REQ-012 Port act_data_out / act_valid_out  output  LANES*ACT_WIDTH / 1  act_data_in and act_valid_in registered one cycle, for systolic forwarding.
REQ-013 Port result_out  output  PE_OUT_WIDTH  accumulator register contents.
REQ-014 Port sat_flag  output  1  sticky overflow flag (PE_SAT_EN only; tied 0 otherwise).

Function
REQ-015 Two weight banks of LANES*WGT_WIDTH SHALL exist; active pointer selects bank used by WS multiply, other bank is shadow.
REQ-016 wgt_load=1 SHALL write wgt_data_in into the shadow bank (as indexed before any same-cycle swap).
REQ-017 wgt_swap=1 SHALL toggle the active pointer; load+swap same cycle: new data written and becomes active next cycle.
REQ-018 Multiply operand SHALL be wgt_data_in when mode=1, active bank when mode=0.
REQ-019 Stage 1: LANES signed products summed into a product-sum register (width ACT_WIDTH+WGT_WIDTH+clog2(LANES)), plus registered valid and mode/drain bits; latency 1.
REQ-020 Stage 2 WS: acc <= result_in + psum if stage-1 valid, else acc <= result_in; result_in is aligned to stage-1 output (one cycle after its act_data_in).
REQ-021 Stage 2 OS: acc <= acc + psum if stage-1 valid, else hold.
REQ-022 os_drain=1 (stage-aligned) SHALL load acc <= result_in, overriding accumulate in both modes.
REQ-023 Total latency act_data_in -> result_out SHALL be 2 cycles; throughput one vector per cycle, no stalls.
REQ-024 Sum SHALL be sign-extended; overflow behaviour per REQ-030/031.
REQ-025 Mode change mid-stream SHALL take effect per-vector via the pipelined mode bit; no flush required.

Reset
REQ-026 reset SHALL clear both weight banks, active pointer (bank 0), psum, stage valid, acc, act_data_out, act_valid_out, sat_flag to 0.
REQ-027 reset SHALL dominate all op_in bits in the same cycle; in-flight stage-1 data SHALL be discarded.
REQ-028 result_out SHALL read 0 the cycle after reset deasserts.

Configuration
REQ-029 Macro PE_SAT_EN SHALL select stage-2 overflow handling.
REQ-030 With PE_SAT_EN: adds in PE_OUT_WIDTH+1 bits, clamp to signed min/max, set sat_flag sticky until reset.
REQ-031 Without PE_SAT_EN: two's-complement wrap at PE_OUT_WIDTH, sat_flag constant 0.

Structure
REQ-032 Package pe_pkg SHALL hold op_in bit index constants, mode enum (WS/OS) and psum width function.
REQ-033 Sub-module pe_wgt_bank SHALL implement the double-buffered weight storage and pointer.

Verification
REQ-034 WS: load w=[1,2,3,4], swap, act=[1,1,1,1] valid, result_in=100 -> result_out=110 two cycles later.
REQ-035 Load+swap same cycle with w=[-1,-1,-1,-1] over active [2,2,2,2], then act=[3,0,0,0] -> psum -3 (new bank used).
REQ-036 OS: 3 valid cycles act=[2,2,2,2], wgt=[1,1,1,1] -> acc 8,16,24; invalid cycle -> holds 24; drain with result_in=7 -> 7.
REQ-037 PE_SAT_EN: acc=0x7FFFFFF0, psum=+32 -> result_out=0x7FFFFFFF, sat_flag=1; without macro -> 0x80000010, flag 0.
REQ-038 Reset asserted mid-OS accumulation with valid in stage 1 -> next cycle result_out=0, act_valid_out=0, bank contents 0.
